// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: unpacks the EX/MEM bundle, runs the data-memory handshake, drives WB and redirect.
// Defining MEM_TIMEOUT_EN adds an access timeout that aborts with a mem_err pulse.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [140:0] ex_mem_bus,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_we,
    output logic [31:0]  mem_req_addr,
    output logic [31:0]  mem_req_wdata,
    input  logic         mem_rsp_valid,
    input  logic [31:0]  mem_rsp_rdata,
    output logic         wb_valid,
    output logic         wb_regwrite,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic         mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      r_state;
    logic        r_req_valid;
    logic        r_req_we;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic        r_wb_valid;
    logic        r_wb_regwrite;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_mem_err;
    logic        r_regwrite;
    logic        r_redir;
    logic        r_ld_sel;

    logic [31:0] w_alu;
    logic [31:0] w_rd2;
    logic [4:0]  w_rd;
    logic        w_memtoreg;
    logic        w_memwrite;
    logic        w_memread;
    logic        w_regwrite;
    logic [31:0] w_adder;
    logic        w_unused_zero;
    logic        w_jalr;
    logic        w_orgate;
    logic [31:0] w_pcbr;
    logic        w_jal;
    logic        w_memop;
    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic [31:0] w_wb_base;
    logic        w_ld_sel;
    logic        w_expired;
    logic        w_hs_done;
    logic        w_abort;

    assign w_alu         = ex_mem_bus[31:0];
    assign w_rd2         = ex_mem_bus[63:32];
    assign w_rd          = ex_mem_bus[68:64];
    assign w_memtoreg    = ex_mem_bus[69];
    assign w_memwrite    = ex_mem_bus[70];
    assign w_memread     = ex_mem_bus[71];
    assign w_regwrite    = ex_mem_bus[72];
    assign w_adder       = ex_mem_bus[104:73];
    assign w_unused_zero = ex_mem_bus[105];
    assign w_jalr        = ex_mem_bus[106];
    assign w_orgate      = ex_mem_bus[107];
    assign w_pcbr        = ex_mem_bus[139:108];
    assign w_jal         = ex_mem_bus[140];

    assign w_memop    = w_memread | w_memwrite;
    assign w_redir    = w_orgate | w_jalr;
    assign w_redir_pc = w_jalr ? {w_alu[31:1], 1'b0} : w_adder;
    // Load data is zero until a response lands; it only replaces the base for true loads.
    assign w_wb_base  = w_jal ? w_pcbr : (w_memtoreg ? 32'h0 : w_alu);
    assign w_ld_sel   = w_memtoreg & ~w_jal & w_memread & ~w_memwrite;

    assign stall = ((r_state == IDLE) && w_memop)
                 || (r_state == REQ) || (r_state == WAIT_RSP);

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state == IDLE || r_state == DONE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [TO_W-1:0] w_unused_to;
    assign w_unused_to = TO_W'(TIMEOUT_CYCLES - 1);
    assign w_expired   = 1'b0;
`endif

    assign w_hs_done = ((r_state == REQ) && mem_req_ready && r_req_we)
                     || ((r_state == WAIT_RSP) && mem_rsp_valid);
    assign w_abort   = w_expired
                     && (((r_state == REQ) && !mem_req_ready)
                     || ((r_state == WAIT_RSP) && !mem_rsp_valid));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_req_valid      <= 1'b0;
            r_req_we         <= 1'b0;
            r_req_addr       <= '0;
            r_req_wdata      <= '0;
            r_wb_valid       <= 1'b0;
            r_wb_regwrite    <= 1'b0;
            r_wb_rd          <= '0;
            r_wb_data        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_mem_err        <= 1'b0;
            r_regwrite       <= 1'b0;
            r_redir          <= 1'b0;
            r_ld_sel         <= 1'b0;
        end else begin
            r_wb_valid       <= 1'b0;
            r_wb_regwrite    <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_mem_err        <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_wb_rd       <= w_rd;
                    r_wb_data     <= w_wb_base;
                    r_redirect_pc <= w_redir_pc;
                    if (w_memop) begin
                        r_req_valid <= 1'b1;
                        r_req_we    <= w_memwrite;
                        r_req_addr  <= w_alu;
                        r_req_wdata <= w_rd2;
                        r_regwrite  <= w_regwrite;
                        r_redir     <= w_redir;
                        r_ld_sel    <= w_ld_sel;
                        r_state     <= REQ;
                    end else begin
                        r_wb_valid       <= 1'b1;
                        r_wb_regwrite    <= w_regwrite;
                        r_redirect_valid <= w_redir;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_req_we ? DONE : WAIT_RSP;
                    end else if (w_abort) begin
                        r_req_valid <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        if (r_ld_sel) r_wb_data <= mem_rsp_rdata;
                        r_state <= DONE;
                    end else if (w_abort) begin
                        r_state <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
            endcase
            if (w_hs_done || w_abort) begin
                r_wb_valid       <= 1'b1;
                r_wb_regwrite    <= r_regwrite & ~w_abort;
                r_redirect_valid <= r_redir;
                r_mem_err        <= w_abort;
            end
        end
    end

    assign mem_req_valid  = r_req_valid;
    assign mem_req_we     = r_req_we;
    assign mem_req_addr   = r_req_addr;
    assign mem_req_wdata  = r_req_wdata;
    assign wb_valid       = r_wb_valid;
    assign wb_regwrite    = r_wb_regwrite;
    assign wb_rd          = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign mem_err        = r_mem_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, hand sequences, randomized model run.
// The timeout sequence is compiled in when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [140:0] bus;
    logic         stall;
    logic         mem_req_valid;
    logic         ready;
    logic         mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_wdata;
    logic         rsp_v;
    logic [31:0]  rdata;
    logic         wb_valid;
    logic         wb_regwrite;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ex_mem_bus    (bus),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (rsp_v),
        .mem_rsp_rdata (rdata),
        .wb_valid      (wb_valid),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_err       (mem_err)
    );

    typedef struct {
        logic [140:0] bus;
        logic         rw;
        logic [4:0]   rd;
        logic [31:0]  data;
        logic         rv;
        logic [31:0]  rpc;
    } vec_t;

    typedef struct {
        int          id;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rpc;
        bit          needs_load;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [140:0] mk(
        input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd,
        input logic m2r, input logic mw, input logic mr, input logic rw,
        input logic [31:0] adder, input logic zero, input logic jalr,
        input logic org, input logic [31:0] pcbr, input logic jal);
        return {jal, pcbr, org, jalr, zero, adder, rw, mr, mw, m2r, rd, rd2, alu};
    endfunction

    function automatic exp_t model(input logic [140:0] b, input int id);
        exp_t e;
        logic is_load;
        is_load      = b[71] && !b[70];
        e.id         = id;
        e.rw         = b[72];
        e.rd         = b[68:64];
        e.needs_load = b[69] && !b[140] && is_load;
        e.data       = b[140] ? b[139:108] : (b[69] ? 32'h0 : b[31:0]);
        e.rv         = b[107] | b[106];
        e.rpc        = b[106] ? (b[31:0] & 32'hFFFF_FFFE) : b[104:73];
        return e;
    endfunction

    function automatic logic [140:0] rnd_bundle();
        int   k;
        logic mr;
        logic mw;
        logic m2r;
        k   = $urandom_range(0, 4);
        mw  = (k == 2);
        mr  = (k == 1) || (k == 2 && $urandom_range(0, 3) == 0);
        m2r = (k == 1) && ($urandom_range(0, 3) != 0);
        if (k == 4) return '0;
        return mk($urandom, $urandom, 5'($urandom), m2r, mw, mr, 1'($urandom),
                  $urandom, 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0);
    endfunction

    task automatic chk_wb(input string tag, input logic rw, input logic [4:0] rd,
                          input logic [31:0] data, input logic rv, input logic [31:0] rpc);
        chk($sformatf("%s wb_valid", tag), wb_valid, 1);
        chk($sformatf("%s wb_regwrite", tag), wb_regwrite, rw);
        chk($sformatf("%s wb_rd", tag), wb_rd, rd);
        chk($sformatf("%s wb_data", tag), wb_data, data);
        chk($sformatf("%s redirect_valid", tag), redirect_valid, rv);
        chk($sformatf("%s redirect_pc", tag), redirect_pc, rpc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus   = '0;
        ready = 1'b0;
        rsp_v = 1'b0;
        rdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_random(input int n);
        logic [140:0] cur;
        exp_t e;
        int   cur_id   = 0;
        int   n_adv    = 0;
        int   pend     = -1;
        int   hs       = 0;
        int   budget   = 0;
        bit   cur_done = 0;
        bit   cur_mem;
        bit   adv;
        cur     = rnd_bundle();
        cur_mem = cur[71] | cur[70];
        q.push_back(model(cur, cur_id));
        bus = cur;
        while (n_adv < n && budget < n * 30) begin
            budget++;
            ready = ($urandom_range(0, 2) != 0);
            rsp_v = 1'b0;
            if (pend == 0) begin
                rsp_v = 1'b1;
                rdata = $urandom;
                if (q.size() > 0 && q[$].needs_load) q[$].data = rdata;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end else if ($urandom_range(0, 3) == 0) begin
                rsp_v = 1'b1;
                rdata = $urandom;
            end
            @(negedge clk);
            if (wb_valid) begin
                if (q.size() == 0) begin
                    chk("rnd unexpected wb_valid", wb_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk_wb("rnd", e.rw, e.rd, e.data, e.rv, e.rpc);
                    if (e.id == cur_id) cur_done = 1;
                end
            end
            chk("rnd stall", stall, cur_mem && !cur_done);
            if (mem_req_valid && ready) begin
                chk("rnd request count", hs, 0);
                chk("rnd request for memop", cur_mem, 1);
                chk("rnd req addr", mem_req_addr, cur[31:0]);
                chk("rnd req wdata", mem_req_wdata, cur[63:32]);
                chk("rnd req we", mem_req_we, cur[70]);
                hs++;
                if (!cur[70]) pend = $urandom_range(0, 2);
            end
            adv = !stall;
            tick();
            if (adv) begin
                if (cur_mem) chk("rnd one request", hs, 1);
                n_adv++;
                hs       = 0;
                cur_done = 0;
                cur_id++;
                if (n_adv < n) begin
                    cur = rnd_bundle();
                    q.push_back(model(cur, cur_id));
                end else begin
                    cur = '0;
                end
                cur_mem = cur[71] | cur[70];
                bus     = cur;
            end
        end
        chk("rnd cycle budget", n_adv, n);
        rsp_v = 1'b0;
        if (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk_wb("rnd last", e.rw, e.rd, e.data, e.rv, e.rpc);
        end
        chk("rnd queue drained", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [140:0] ld;
        logic [140:0] st;
        tbl[0] = '{mk(32'h1234, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                   1, 5, 32'h1234, 0, 32'h0};
        tbl[1] = '{mk(32'h10, 0, 1, 0, 0, 0, 1, 32'h80, 0, 0, 1, 32'h44, 1),
                   1, 1, 32'h44, 1, 32'h80};
        tbl[2] = '{mk(32'h203, 0, 3, 0, 0, 0, 1, 32'h90, 0, 1, 0, 0, 0),
                   1, 3, 32'h203, 1, 32'h202};
        tbl[3] = '{'0, 0, 0, 32'h0, 0, 32'h0};
        tbl[4] = '{mk(32'hFFFF_FFFF, 32'h5, 31, 0, 0, 0, 1, 32'h1000, 1, 0, 0, 0, 0),
                   1, 31, 32'hFFFF_FFFF, 0, 32'h1000};
        tbl[5] = '{mk(32'h1001, 0, 2, 0, 0, 0, 0, 32'h500, 0, 1, 1, 32'h8, 0),
                   0, 2, 32'h1001, 1, 32'h1000};

        reset = 1'b1;
        bus   = '0;
        ready = 1'b0;
        rsp_v = 1'b0;
        rdata = '0;
        tick();
        tick();
        @(negedge clk);
        chk("reset mem_req_valid", mem_req_valid, 0);
        chk("reset wb_valid", wb_valid, 0);
        chk("reset wb_data", wb_data, 0);
        chk("reset redirect_valid", redirect_valid, 0);
        chk("reset mem_err", mem_err, 0);
        chk("reset stall", stall, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            bus = tbl[i].bus;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), stall, 0);
            tick();
            chk_wb($sformatf("vec%0d", i), tbl[i].rw, tbl[i].rd, tbl[i].data,
                   tbl[i].rv, tbl[i].rpc);
        end

        // load, ready high, response one cycle after handshake
        ld    = mk(32'h100, 0, 9, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        bus   = ld;
        ready = 1'b1;
        @(negedge clk);
        chk("load idle stall", stall, 1);
        chk("load idle req_valid", mem_req_valid, 0);
        tick();
        @(negedge clk);
        chk("load req_valid", mem_req_valid, 1);
        chk("load req addr", mem_req_addr, 32'h100);
        chk("load req we", mem_req_we, 0);
        chk("load req stall", stall, 1);
        tick();
        rsp_v = 1'b1;
        rdata = 32'hCAFE_BABE;
        @(negedge clk);
        chk("load wait req_valid", mem_req_valid, 0);
        chk("load wait stall", stall, 1);
        tick();
        rsp_v = 1'b0;
        @(negedge clk);
        chk_wb("load done", 1, 9, 32'hCAFE_BABE, 0, 32'h0);
        chk("load done stall", stall, 0);
        tick();
        bus = '0;
        @(negedge clk);
        chk("load single wb", wb_valid, 0);
        chk("load single request", mem_req_valid, 0);
        tick();
        @(negedge clk);
        chk_wb("bubble", 0, 0, 32'h0, 0, 32'h0);
        tick();

        // store with ready held low for three cycles
        st    = mk(32'h200, 32'hDEAD, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bus   = st;
        ready = 1'b0;
        @(negedge clk);
        chk("store idle stall", stall, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready = 1'b1;
            @(negedge clk);
            chk($sformatf("store c%0d req_valid", i), mem_req_valid, 1);
            chk($sformatf("store c%0d addr", i), mem_req_addr, 32'h200);
            chk($sformatf("store c%0d wdata", i), mem_req_wdata, 32'hDEAD);
            chk($sformatf("store c%0d we", i), mem_req_we, 1);
            chk($sformatf("store c%0d stall", i), stall, 1);
            tick();
        end
        ready = 1'b0;
        @(negedge clk);
        chk_wb("store done", 0, 4, 32'h200, 0, 32'h0);
        chk("store done stall", stall, 0);
        chk("store done req_valid", mem_req_valid, 0);
        tick();

        // MemRead and MemWrite together behave as a store
        bus   = mk(32'h500, 32'h77, 8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        ready = 1'b1;
        @(negedge clk);
        chk("rw idle stall", stall, 1);
        tick();
        @(negedge clk);
        chk("rw req we", mem_req_we, 1);
        chk("rw req wdata", mem_req_wdata, 32'h77);
        tick();
        @(negedge clk);
        chk_wb("rw done", 1, 8, 32'h500, 0, 32'h0);
        tick();
        bus = '0;

        // reset while in REQ
        bus   = mk(32'h300, 0, 7, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        ready = 1'b0;
        tick();
        @(negedge clk);
        chk("rst-req req_valid", mem_req_valid, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus   = '0;
        rsp_v = 1'b1;
        rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("rst-req req_valid", mem_req_valid, 0);
        chk("rst-req addr", mem_req_addr, 0);
        chk("rst-req wdata", mem_req_wdata, 0);
        chk("rst-req wb_valid", wb_valid, 0);
        chk("rst-req wb_data", wb_data, 0);
        chk("rst-req stall", stall, 0);
        chk("rst-req mem_err", mem_err, 0);
        tick();
        rsp_v = 1'b0;
        @(negedge clk);
        chk_wb("rst-req bubble", 0, 0, 32'h0, 0, 32'h0);
        tick();

        // reset while in WAIT_RSP, late response must be ignored
        bus   = mk(32'h400, 0, 6, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst-wait stall", stall, 1);
        tick();
        reset = 1'b0;
        bus   = mk(32'h404, 32'h1, 6, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        ready = 1'b0;
        rsp_v = 1'b1;
        rdata = 32'h1111_2222;
        @(negedge clk);
        chk("rst-wait req_valid", mem_req_valid, 0);
        chk("rst-wait wb_valid", wb_valid, 0);
        chk("rst-wait wb_data", wb_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            rsp_v = (i == 0);
            @(negedge clk);
            chk($sformatf("rst-wait late rsp c%0d", i), wb_valid, 0);
        end

`ifdef MEM_TIMEOUT_EN
        do_reset();
        bus   = mk(32'h600, 32'h9, 6, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        ready = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("timeout c%0d req_valid", i), mem_req_valid, 1);
            chk($sformatf("timeout c%0d mem_err", i), mem_err, 0);
            tick();
        end
        @(negedge clk);
        chk("timeout mem_err", mem_err, 1);
        chk("timeout wb_valid", wb_valid, 1);
        chk("timeout wb_regwrite", wb_regwrite, 0);
        chk("timeout req_valid", mem_req_valid, 0);
        chk("timeout stall", stall, 0);
        tick();
        bus = '0;
        @(negedge clk);
        chk("timeout mem_err pulse", mem_err, 0);
`else
        do_reset();
        bus   = mk(32'h600, 32'h9, 6, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        ready = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("no-timeout c%0d req_valid", i), mem_req_valid, 1);
            chk($sformatf("no-timeout c%0d mem_err", i), mem_err, 0);
            tick();
        end
        ready = 1'b1;
        tick();
        @(negedge clk);
        chk_wb("no-timeout done", 1, 6, 32'h600, 0, 32'h0);
        chk("no-timeout mem_err", mem_err, 0);
`endif

        do_reset();
        run_random(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the 141-bit EX/MEM pipeline bundle.
- Unpacks the bundle and runs data-memory loads/stores over a valid/ready request and response handshake.
- Stalls the upstream pipeline registers while an access is outstanding.
- Produces a registered writeback bundle and a PC redirect for the WB stage and fetch.

Parameters:
- TIMEOUT_CYCLES, 16: cycles allowed in REQ+WAIT_RSP before abort. Used only with MEM_TIMEOUT_EN.
- TO_W, 5: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_bus  in  141  EX/MEM bundle; field layout is given under Behaviour.
- stall  out  1  combinational; upstream pipeline enable = ~stall.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = store, 0 = load.
- mem_req_addr  out  32  ALU result latched from the bundle.
- mem_req_wdata  out  32  Rd2 latched from the bundle.
- mem_rsp_valid  in  1  load data valid.
- mem_rsp_rdata  in  32  load data.
- wb_valid  out  1  one-cycle pulse; writeback fields are valid.
- wb_regwrite  out  1  register write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- redirect_valid  out  1  taken branch or jump.
- redirect_pc  out  32  redirect target.
- mem_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Bundle fields:
  - [31:0] ALU_result
  - [63:32] Rd2
  - [68:64] RD
  - [69] MemToReg
  - [70] MemWrite
  - [71] MemRead
  - [72] RegWrite
  - [104:73] ADDER_PC_PLUS_IMM
  - [105] Zero
  - [106] Jalr
  - [107] Orgate
  - [139:108] PCBR
  - [140] jal
- An all-zero bundle is a bubble: wb_valid pulses with wb_regwrite=0.
- memop = MemRead | MemWrite. If both bits are set, the access is treated as a store.
- wb_data selection, in priority order:
  - jal → PCBR
  - else MemToReg → load data
  - else ALU_result
- redirect_valid = Orgate | Jalr.
- redirect_pc = Jalr ? {ALU_result[31:1],1'b0} : ADDER_PC_PLUS_IMM.
- All wb_* and redirect_* outputs are registered and meaningful only while wb_valid=1.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, memop=0: at the next edge, register the writeback/redirect outputs and pulse wb_valid for 1 cycle. State stays IDLE. Latency is 1 cycle.
- IDLE, memop=1:
  - stall=1 combinationally in this same cycle.
  - Latch addr, wdata, we and all writeback fields.
  - Go to REQ.
- REQ:
  - mem_req_valid=1; addr, wdata and we held stable until mem_req_ready=1.
  - On handshake: a store goes to DONE; a load goes to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, capture mem_rsp_rdata and go to DONE. mem_rsp_valid seen in any other state is ignored.
- DONE:
  - wb_valid=1 with the captured fields; stall=0, so upstream loads the next instruction at this edge.
  - Go to IDLE; the bundle is not sampled in DONE.
- stall = (IDLE & memop) | REQ | WAIT_RSP.
- Minimum load latency with ready=1 and the response one cycle later: IDLE→REQ→WAIT_RSP→DONE, so wb_valid appears in the 4th cycle.
- Reset:
  - All outputs 0, state IDLE.
  - Reset in REQ drops mem_req_valid with no handshake.
  - A response arriving after reset is ignored.
  - Reset has priority over every other event.
- Only word accesses are supported; the address is passed through unmodified.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP.
  - When the counter reaches TIMEOUT_CYCLES-1 without the awaited handshake, go to DONE with mem_err=1 for 1 cycle.
  - On abort: load data=0, wb_regwrite forced to 0, mem_req_valid dropped.
- MEM_TIMEOUT_EN undefined: no counter; the block waits indefinitely and mem_err is tied to 0.

Test Plan:
- Bundle with RegWrite=1, RD=5, ALU_result=0x1234, no memop → next cycle wb_valid=1, wb_rd=5, wb_data=0x1234; stall never asserted.
- Load: MemRead=1, MemToReg=1, addr=0x100, ready=1, rsp 1 cycle later with 0xCAFEBABE → stall high 3 cycles, single request with addr 0x100, wb_data=0xCAFEBABE in DONE.
- Store: MemWrite=1, Rd2=0xDEAD, ready held low 3 cycles → addr/wdata/we stable all 3 cycles; DONE 1 cycle after ready; wb_regwrite=0.
- jal=1, PCBR=0x44, Orgate=1, ADDER=0x80 → wb_data=0x44, redirect_valid=1, redirect_pc=0x80. Jalr=1, ALU_result=0x203 → redirect_pc=0x202.
- Reset asserted in REQ and in WAIT_RSP → next cycle all outputs 0, state IDLE; a later mem_rsp_valid produces no wb_valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready held low → mem_err pulses after 16 cycles in REQ, wb_regwrite=0, stall released.
